// File: rtl/vcfg_ctrl.sv
// Vector configuration controller: decodes vsetvli/vsetivli/vsetvl/vsetsh, waits for the
// vector datapath to drain, commits vl/vtype/vshamt and answers on a valid/ready channel.
module vcfg_ctrl #(
    parameter  int VLEN    = 4096,
    parameter  int ELEN    = 64,
    parameter  int XLEN    = 64,
    localparam int VlWidth = $clog2(VLEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [31:0]        req_instr_i,
    input  logic [XLEN-1:0]    req_rs1_i,
    input  logic [XLEN-1:0]    req_rs2_i,
    input  logic               vec_idle_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [4:0]         resp_rd_o,
    output logic [XLEN-1:0]    resp_result_o,
    output logic               resp_illegal_o,
    output logic [VlWidth-1:0] vl_o,
    output logic [8:0]         vtype_o,
    output logic [7:0]         vshamt_o,
    output logic               busy_o
);
    // Request handshake: an instruction transfers on a clk_i edge with req_valid_i && req_ready_o;
    // a response transfers on an edge with resp_valid_o && resp_ready_i, fields held until then.
    typedef enum logic [1:0] {IDLE, DRAIN, COMPUTE, RESP} state_e;
    typedef enum logic [2:0] {K_VSETVLI, K_VSETIVLI, K_VSETVL, K_VSETSH, K_ILL} kind_e;

    localparam logic [XLEN-1:0] VlenX   = XLEN'(VLEN);
    localparam logic [XLEN-1:0] ElenX   = XLEN'(ELEN);
    localparam logic [XLEN-1:0] EightX  = XLEN'(8);
    localparam logic [2:0]      SewMax  = 3'($clog2(ELEN / 8));

    state_e state_q, state_d;
    logic [31:0]        instr_q;
    logic [XLEN-1:0]    rs1_q, rs2_q;
    logic [VlWidth-1:0] vl_q, vl_new;
    logic [8:0]         vtype_q, vtype_new;
    logic [7:0]         vshamt_q, vshamt_new;
    logic [4:0]         resp_rd_q;
    logic [XLEN-1:0]    resp_result_q, result_new;
    logic               resp_illegal_q;
    logic               accept;

    function automatic kind_e decode(input logic [31:0] ins);
        kind_e k;
        if (ins[6:0] != 7'b1010111 || ins[14:12] != 3'b111) k = K_ILL;
        else if (!ins[31])                                  k = K_VSETVLI;
        else if (ins[31:30] == 2'b11)                       k = K_VSETIVLI;
        else if (ins[31:25] == 7'b1000000)                  k = K_VSETVL;
        else if (ins[31:28] == 4'b1010)                     k = K_VSETSH;
        else                                                k = K_ILL;
        return k;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = (decode(req_instr_i) == K_ILL) ? RESP : DRAIN;
            DRAIN:   if (vec_idle_i) state_d = COMPUTE;
            COMPUTE: state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == IDLE);
        busy_o       = (state_q != IDLE);
        resp_valid_o = (state_q == RESP);
    end

    assign accept = req_valid_i && (state_q == IDLE);

    kind_e           kind_c;
    logic [XLEN-1:0] vt_raw, vlmax, sew_x, avl, vl_min;
    logic [2:0]      vsew, vlmul;
    logic            vill, keep_vl;

    // vtype legality and the new vl, evaluated from the captured instruction in COMPUTE.
    always_comb begin
        kind_c = decode(instr_q);
        case (kind_c)
            K_VSETVLI:  vt_raw = XLEN'(instr_q[30:20]);
            K_VSETIVLI: vt_raw = XLEN'(instr_q[29:20]);
            default:    vt_raw = rs2_q;
        endcase
        vsew  = vt_raw[5:3];
        vlmul = vt_raw[2:0];
        sew_x = EightX << vsew;
        vlmax = VlenX >> (4'(vsew) + 4'd3);
        if (vlmul[2]) vlmax = vlmax >> (4'd8 - 4'(vlmul));
        else          vlmax = vlmax << vlmul[1:0];
        vill = (vlmul == 3'b100) || (vsew > SewMax) || (|vt_raw[XLEN-1:8])
            || (vlmul[2] && (sew_x > (ElenX >> (4'd8 - 4'(vlmul)))));
        if (kind_c == K_VSETIVLI)     avl = XLEN'(instr_q[19:15]);
        else if (instr_q[19:15] != 0) avl = rs1_q;
        else                          avl = vlmax;
        keep_vl = (kind_c != K_VSETIVLI) && (instr_q[19:15] == 5'd0) && (instr_q[11:7] == 5'd0);
        vl_min  = (avl < vlmax) ? avl : vlmax;

        vl_new     = vl_q;
        vtype_new  = vtype_q;
        vshamt_new = vshamt_q;
        result_new = '0;
        if (kind_c == K_VSETSH) begin
            vshamt_new = instr_q[27:20];
            result_new = XLEN'(instr_q[27:20]);
        end else if (kind_c != K_ILL) begin
            if (vill) begin
                vl_new    = '0;
                vtype_new = 9'h100;
            end else begin
                vtype_new  = {1'b0, vt_raw[7:0]};
                vl_new     = keep_vl ? vl_q : vl_min[VlWidth-1:0];
                result_new = XLEN'(vl_new);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q        <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            vl_q           <= '0;
            vtype_q        <= 9'h100;
            vshamt_q       <= '0;
            resp_rd_q      <= '0;
            resp_result_q  <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                instr_q        <= req_instr_i;
                rs1_q          <= req_rs1_i;
                rs2_q          <= req_rs2_i;
                resp_rd_q      <= req_instr_i[11:7];
                resp_result_q  <= '0;
                resp_illegal_q <= (decode(req_instr_i) == K_ILL);
            end
            if (state_q == COMPUTE) begin
                vl_q          <= vl_new;
                vtype_q       <= vtype_new;
                vshamt_q      <= vshamt_new;
                resp_result_q <= result_new;
            end
        end
    end

    assign vl_o           = vl_q;
    assign vtype_o        = vtype_q;
    assign vshamt_o       = vshamt_q;
    assign resp_rd_o      = resp_rd_q;
    assign resp_result_o  = resp_result_q;
    assign resp_illegal_o = resp_illegal_q;
endmodule

// File: tb/tb_vcfg_ctrl.sv
// Bench for vcfg_ctrl: directed scenarios plus randomized instructions against an
// arithmetic reference model of the vector configuration rules.
module tb_vcfg_ctrl;
    localparam int VLEN = 4096;
    localparam int ELEN = 64;
    localparam int XLEN = 64;
    localparam int VLW  = 13;

    logic            clk_i, rst_i;
    logic            req_valid_i, req_ready_o;
    logic [31:0]     req_instr_i;
    logic [XLEN-1:0] req_rs1_i, req_rs2_i;
    logic            vec_idle_i;
    logic            resp_valid_o, resp_ready_i;
    logic [4:0]      resp_rd_o;
    logic [XLEN-1:0] resp_result_o;
    logic            resp_illegal_o;
    logic [VLW-1:0]  vl_o;
    logic [8:0]      vtype_o;
    logic [7:0]      vshamt_o;
    logic            busy_o;

    vcfg_ctrl #(.VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .vec_idle_i(vec_idle_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rd_o(resp_rd_o),
        .resp_result_o(resp_result_o), .resp_illegal_o(resp_illegal_o),
        .vl_o(vl_o), .vtype_o(vtype_o), .vshamt_o(vshamt_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state and expectations for the last issued instruction.
    logic [VLW-1:0]  m_vl;
    logic [8:0]      m_vtype;
    logic [7:0]      m_vshamt;
    logic [XLEN-1:0] exp_res;
    logic            exp_ill;
    logic [4:0]      exp_rd;

    // Observations gathered by the driver.
    int              o_lat;
    logic [XLEN-1:0] o_res;
    logic [4:0]      o_rd;
    logic            o_ill, o_stable, o_early, o_hs;

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] z);
        return {1'b0, z, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] u5, input logic [9:0] z);
        return {2'b11, z, u5, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] enc_vsetsh(input logic [4:0] rd, input logic [7:0] u8);
        return {4'b1010, u8, 5'd0, 3'b111, rd, 7'h57};
    endfunction

    task automatic model_apply(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
        logic [63:0] vt;
        longint unsigned avl, vlmax, newvl;
        int sew, num, den, lm, form;
        bit bad;
        exp_rd  = ins[11:7];
        exp_ill = 1'b0;
        exp_res = '0;
        form    = -1;
        vt      = '0;
        if (ins[6:0] != 7'h57 || ins[14:12] != 3'd7) exp_ill = 1'b1;
        else if (ins[31] == 1'b0)          begin form = 0; vt = 64'(ins[30:20]); end
        else if (ins[31:30] == 2'b11)      begin form = 1; vt = 64'(ins[29:20]); end
        else if (ins[31:25] == 7'b1000000) begin form = 2; vt = r2; end
        else if (ins[31:28] == 4'b1010)    begin form = 3; end
        else exp_ill = 1'b1;
        if (form == 3) begin
            m_vshamt = ins[27:20];
            exp_res  = 64'(ins[27:20]);
        end else if (form >= 0) begin
            sew = 8 << int'(vt[5:3]);
            lm  = int'(vt[2:0]);
            num = 1; den = 1;
            if (lm < 4) num = 1 << lm;
            else if (lm > 4) den = 1 << (8 - lm);
            bad = (vt[63:8] != 0) || (lm == 4) || (sew > ELEN) || (sew * den > ELEN * num);
            if (bad) begin
                m_vl    = '0;
                m_vtype = 9'h100;
            end else begin
                vlmax = longint'(VLEN * num / (sew * den));
                if (form == 1)           avl = longint'(ins[19:15]);
                else if (ins[19:15] != 0) avl = r1;
                else                     avl = vlmax;
                if (form != 1 && ins[19:15] == 0 && ins[11:7] == 0) newvl = longint'(m_vl);
                else newvl = (avl < vlmax) ? avl : vlmax;
                m_vl    = VLW'(newvl);
                m_vtype = {1'b0, vt[7:0]};
                exp_res = 64'(newvl);
            end
        end
    endtask

    // Issue one instruction, hold vec_idle_i low for d_idle cycles, stall the response r_dly cycles.
    task automatic do_op(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                         input int d_idle, input int r_dly);
        int guard;
        logic [VLW-1:0] pre_vl;
        logic [8:0] pre_vtype;
        logic [7:0] pre_vshamt;
        guard = 0;
        while (req_ready_o !== 1'b1 && guard < 50) begin @(posedge clk_i); #1; guard++; end
        if (req_ready_o !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_wait: ready=%0b exp 1", req_ready_o);
        end
        pre_vl = m_vl; pre_vtype = m_vtype; pre_vshamt = m_vshamt;
        model_apply(ins, r1, r2);
        req_valid_i = 1'b1; req_instr_i = ins; req_rs1_i = r1; req_rs2_i = r2;
        vec_idle_i  = (d_idle == 0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        o_lat = 1; o_stable = 1'b1; o_early = 1'b0; o_hs = 1'b1;
        while (resp_valid_o !== 1'b1 && o_lat < 300) begin
            if (req_ready_o !== 1'b0 || busy_o !== 1'b1) o_hs = 1'b0;
            if (!vec_idle_i && (vl_o !== pre_vl || vtype_o !== pre_vtype || vshamt_o !== pre_vshamt)) o_early = 1'b1;
            if (o_lat >= d_idle) vec_idle_i = 1'b1;
            @(posedge clk_i); #1;
            o_lat++;
        end
        if (resp_valid_o !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles exp 1", resp_valid_o, o_lat);
        end
        o_res = resp_result_o; o_rd = resp_rd_o; o_ill = resp_illegal_o;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o !== 1'b1 || resp_result_o !== o_res || resp_rd_o !== o_rd || resp_illegal_o !== o_ill)
                o_stable = 1'b0;
            if (req_ready_o !== 1'b0) o_hs = 1'b0;
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) o_hs = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        m_vl = '0; m_vtype = 9'h100; m_vshamt = '0;
        n_checks++; if (vl_o !== 13'd0) begin n_fail++; $display("FAIL rst_vl: got %0d exp 0", vl_o); end else n_pass++;
        n_checks++; if (vtype_o !== 9'h100) begin n_fail++; $display("FAIL rst_vtype: got %0h exp 100", vtype_o); end else n_pass++;
        n_checks++; if (vshamt_o !== 8'd0) begin n_fail++; $display("FAIL rst_vshamt: got %0h exp 0", vshamt_o); end else n_pass++;
        n_checks++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b exp 0", resp_valid_o); end else n_pass++;
        n_checks++; if (resp_illegal_o !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %0b exp 0", resp_illegal_o); end else n_pass++;
        n_checks++; if (resp_result_o !== 64'd0) begin n_fail++; $display("FAIL rst_result: got %0h exp 0", resp_result_o); end else n_pass++;
        n_checks++; if (resp_rd_o !== 5'd0) begin n_fail++; $display("FAIL rst_rd: got %0d exp 0", resp_rd_o); end else n_pass++;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b exp 0", busy_o); end else n_pass++;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b exp 1", req_ready_o); end else n_pass++;
    endtask

    task automatic test_vsetvli_basic();
        do_op(enc_vsetvli(5'd6, 5'd5, 11'h010), 64'd100, 64'd0, 0, 0);
        n_checks++; if (o_lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d exp 3", o_lat); end else n_pass++;
        n_checks++; if (vl_o !== 13'd100) begin n_fail++; $display("FAIL basic_vl: got %0d exp 100", vl_o); end else n_pass++;
        n_checks++; if (vtype_o !== 9'h010) begin n_fail++; $display("FAIL basic_vtype: got %0h exp 010", vtype_o); end else n_pass++;
        n_checks++; if (o_res !== 64'd100) begin n_fail++; $display("FAIL basic_result: got %0d exp 100", o_res); end else n_pass++;
        n_checks++; if (o_rd !== 5'd6) begin n_fail++; $display("FAIL basic_rd: got %0d exp 6", o_rd); end else n_pass++;
        n_checks++; if (o_ill !== 1'b0) begin n_fail++; $display("FAIL basic_illegal: got %0b exp 0", o_ill); end else n_pass++;
        n_checks++; if (o_hs !== 1'b1) begin n_fail++; $display("FAIL basic_handshake: got %0b exp 1", o_hs); end else n_pass++;
    endtask

    task automatic test_vlmax_modes();
        do_op(enc_vsetvli(5'd1, 5'd0, 11'h003), 64'd0, 64'd0, 0, 0);
        n_checks++; if (vl_o !== 13'd4096) begin n_fail++; $display("FAIL m8_vl: got %0d exp 4096", vl_o); end else n_pass++;
        n_checks++; if (o_res !== 64'd4096) begin n_fail++; $display("FAIL m8_result: got %0d exp 4096", o_res); end else n_pass++;
        do_op(enc_vsetvli(5'd0, 5'd0, 11'h00B), 64'd77, 64'd0, 0, 0);
        n_checks++; if (vl_o !== 13'd4096) begin n_fail++; $display("FAIL keep_vl: got %0d exp 4096", vl_o); end else n_pass++;
        n_checks++; if (vtype_o !== 9'h00B) begin n_fail++; $display("FAIL keep_vtype: got %0h exp 00B", vtype_o); end else n_pass++;
        n_checks++; if (o_res !== 64'd4096) begin n_fail++; $display("FAIL keep_result: got %0d exp 4096", o_res); end else n_pass++;
        do_op(enc_vsetivli(5'd2, 5'd17, 10'h000), 64'd0, 64'd0, 0, 0);
        n_checks++; if (vl_o !== 13'd17) begin n_fail++; $display("FAIL ivli_vl: got %0d exp 17", vl_o); end else n_pass++;
        do_op(enc_vsetvli(5'd3, 5'd9, 11'h0C0), 64'hFFFF_FFFF_0000_0010, 64'd0, 0, 0);
        n_checks++; if (vl_o !== 13'd512) begin n_fail++; $display("FAIL wide_avl_vl: got %0d exp 512", vl_o); end else n_pass++;
        n_checks++; if (vtype_o !== 9'h0C0) begin n_fail++; $display("FAIL wide_avl_vtype: got %0h exp 0C0", vtype_o); end else n_pass++;
        do_op(enc_vsetvli(5'd4, 5'd0, 11'h005), 64'd0, 64'd0, 0, 0);
        n_checks++; if (vl_o !== 13'd64) begin n_fail++; $display("FAIL mf8_vl: got %0d exp 64", vl_o); end else n_pass++;
        do_op(enc_vsetvl(5'd1, 5'd0, 5'd7), 64'd0, 64'h17, 0, 0);
        n_checks++; if (vl_o !== 13'd64) begin n_fail++; $display("FAIL e32mf2_vl: got %0d exp 64", vl_o); end else n_pass++;
    endtask

    task automatic test_vill();
        do_op(enc_vsetvl(5'd5, 5'd0, 5'd7), 64'd0, 64'h1D, 0, 0);
        n_checks++; if (vtype_o !== 9'h100) begin n_fail++; $display("FAIL vill_mf8_vtype: got %0h exp 100", vtype_o); end else n_pass++;
        n_checks++; if (vl_o !== 13'd0) begin n_fail++; $display("FAIL vill_mf8_vl: got %0d exp 0", vl_o); end else n_pass++;
        n_checks++; if (o_res !== 64'd0) begin n_fail++; $display("FAIL vill_mf8_result: got %0d exp 0", o_res); end else n_pass++;
        n_checks++; if (o_ill !== 1'b0) begin n_fail++; $display("FAIL vill_mf8_illegal: got %0b exp 0", o_ill); end else n_pass++;
        do_op(enc_vsetvli(5'd1, 5'd0, 11'h003), 64'd0, 64'd0, 0, 0);
        do_op(enc_vsetvl(5'd5, 5'd3, 5'd7), 64'd20, 64'h110, 0, 0);
        n_checks++; if (vtype_o !== 9'h100 || vl_o !== 13'd0) begin n_fail++; $display("FAIL vill_bit8: got vtype %0h vl %0d exp 100 0", vtype_o, vl_o); end else n_pass++;
        do_op(enc_vsetvli(5'd1, 5'd0, 11'h003), 64'd0, 64'd0, 0, 0);
        do_op(enc_vsetvli(5'd1, 5'd0, 11'h004), 64'd0, 64'd0, 0, 0);
        n_checks++; if (vtype_o !== 9'h100 || vl_o !== 13'd0) begin n_fail++; $display("FAIL vill_lmul100: got vtype %0h vl %0d exp 100 0", vtype_o, vl_o); end else n_pass++;
        do_op(enc_vsetvl(5'd1, 5'd0, 5'd7), 64'd0, 64'h18, 0, 0);
        n_checks++; if (vl_o !== 13'd64 || vtype_o !== 9'h018) begin n_fail++; $display("FAIL e64m1_legal: got vtype %0h vl %0d exp 018 64", vtype_o, vl_o); end else n_pass++;
        do_op(enc_vsetvli(5'd1, 5'd0, 11'h020), 64'd0, 64'd0, 0, 0);
        n_checks++; if (vtype_o !== 9'h100) begin n_fail++; $display("FAIL vill_e128: got vtype %0h exp 100", vtype_o); end else n_pass++;
    endtask

    task automatic test_stall();
        do_op(enc_vsetvli(5'd8, 5'd10, 11'h008), 64'd300, 64'd0, 10, 5);
        n_checks++; if (o_lat !== 12) begin n_fail++; $display("FAIL stall_latency: got %0d exp 12", o_lat); end else n_pass++;
        n_checks++; if (o_early !== 1'b0) begin n_fail++; $display("FAIL stall_early_csr: got %0b exp 0", o_early); end else n_pass++;
        n_checks++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL stall_resp_stable: got %0b exp 1", o_stable); end else n_pass++;
        n_checks++; if (o_hs !== 1'b1) begin n_fail++; $display("FAIL stall_req_ready: got %0b exp 1", o_hs); end else n_pass++;
        n_checks++; if (vl_o !== 13'd256 || o_res !== 64'd256) begin n_fail++; $display("FAIL stall_vl: got vl %0d res %0d exp 256", vl_o, o_res); end else n_pass++;
    endtask

    task automatic test_vsetsh_illegal();
        logic [31:0] ins;
        do_op(enc_vsetsh(5'd7, 8'h1F), 64'd5, 64'd9, 0, 0);
        n_checks++; if (vshamt_o !== 8'h1F) begin n_fail++; $display("FAIL sh_vshamt: got %0h exp 1F", vshamt_o); end else n_pass++;
        n_checks++; if (o_res !== 64'h1F) begin n_fail++; $display("FAIL sh_result: got %0h exp 1F", o_res); end else n_pass++;
        n_checks++; if (vl_o !== 13'd256 || vtype_o !== 9'h008) begin n_fail++; $display("FAIL sh_csr_kept: got vl %0d vtype %0h exp 256 008", vl_o, vtype_o); end else n_pass++;
        n_checks++; if (o_rd !== 5'd7) begin n_fail++; $display("FAIL sh_rd: got %0d exp 7", o_rd); end else n_pass++;
        ins = {6'b0, 1'b1, 5'd2, 5'd3, 3'b000, 5'd9, 7'h57};
        do_op(ins, 64'd1, 64'd1, 10, 0);
        n_checks++; if (o_lat !== 1) begin n_fail++; $display("FAIL ill_latency: got %0d exp 1", o_lat); end else n_pass++;
        n_checks++; if (o_ill !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %0b exp 1", o_ill); end else n_pass++;
        n_checks++; if (o_res !== 64'd0 || o_rd !== 5'd9) begin n_fail++; $display("FAIL ill_fields: got res %0h rd %0d exp 0 9", o_res, o_rd); end else n_pass++;
        n_checks++; if (vl_o !== 13'd256 || vtype_o !== 9'h008 || vshamt_o !== 8'h1F) begin n_fail++; $display("FAIL ill_csr_kept: got %0d %0h %0h", vl_o, vtype_o, vshamt_o); end else n_pass++;
        ins = {7'b1001000, 5'd0, 5'd0, 3'b111, 5'd10, 7'h57};
        do_op(ins, 64'd0, 64'd0, 0, 0);
        n_checks++; if (o_ill !== 1'b1 || o_lat !== 1) begin n_fail++; $display("FAIL ill_opcfg: got ill %0b lat %0d exp 1 1", o_ill, o_lat); end else n_pass++;
        ins = enc_vsetvli(5'd1, 5'd0, 11'h003);
        ins[6:0] = 7'h53;
        do_op(ins, 64'd0, 64'd0, 0, 0);
        n_checks++; if (o_ill !== 1'b1 || vl_o !== 13'd256) begin n_fail++; $display("FAIL ill_opcode: got ill %0b vl %0d exp 1 256", o_ill, vl_o); end else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [10:0] vt;
        logic [4:0]  rdf, rs1f;
        logic [63:0] r1, r2;
        int kind, d, r, elat;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            vt   = {(($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000), 2'($urandom),
                    3'($urandom_range(0, 4)), 3'($urandom)};
            rdf  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r1   = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 5000)) : {$urandom, $urandom};
            r2   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'(vt);
            case (kind)
                0: ins = enc_vsetvli(rdf, rs1f, vt);
                1: ins = enc_vsetivli(rdf, rs1f, vt[9:0]);
                2: ins = enc_vsetvl(rdf, rs1f, 5'($urandom));
                3: ins = enc_vsetsh(rdf, 8'($urandom));
                default: begin
                    ins = $urandom;
                    if ($urandom_range(0, 1) == 1) ins[6:0] = 7'h57;
                end
            endcase
            d = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            do_op(ins, r1, r2, d, r);
            elat = exp_ill ? 1 : ((d <= 1) ? 3 : d + 2);
            n_checks++; if (o_lat !== elat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", i, o_lat, elat); end else n_pass++;
            n_checks++; if (o_ill !== exp_ill) begin n_fail++; $display("FAIL rnd_illegal[%0d]: got %0b exp %0b", i, o_ill, exp_ill); end else n_pass++;
            n_checks++; if (o_res !== exp_res) begin n_fail++; $display("FAIL rnd_result[%0d]: got %0h exp %0h", i, o_res, exp_res); end else n_pass++;
            n_checks++; if (o_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %0d exp %0d", i, o_rd, exp_rd); end else n_pass++;
            n_checks++; if (vl_o !== m_vl) begin n_fail++; $display("FAIL rnd_vl[%0d]: got %0d exp %0d", i, vl_o, m_vl); end else n_pass++;
            n_checks++; if (vtype_o !== m_vtype) begin n_fail++; $display("FAIL rnd_vtype[%0d]: got %0h exp %0h", i, vtype_o, m_vtype); end else n_pass++;
            n_checks++; if (vshamt_o !== m_vshamt) begin n_fail++; $display("FAIL rnd_vshamt[%0d]: got %0h exp %0h", i, vshamt_o, m_vshamt); end else n_pass++;
            n_checks++; if (o_stable !== 1'b1 || o_early !== 1'b0 || o_hs !== 1'b1) begin n_fail++; $display("FAIL rnd_protocol[%0d]: stable %0b early %0b hs %0b exp 1 0 1", i, o_stable, o_early, o_hs); end else n_pass++;
        end
    endtask

    task automatic test_reset_in_drain();
        int seen;
        req_valid_i = 1'b1; req_instr_i = enc_vsetvli(5'd6, 5'd5, 11'h010);
        req_rs1_i = 64'd50; req_rs2_i = 64'd0; vec_idle_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %0b exp 1", busy_o); end else n_pass++;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_vl = '0; m_vtype = 9'h100; m_vshamt = '0;
        n_checks++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got busy %0b ready %0b exp 0 1", busy_o, req_ready_o); end else n_pass++;
        n_checks++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_resp_valid: got %0b exp 0", resp_valid_o); end else n_pass++;
        n_checks++; if (vl_o !== 13'd0 || vtype_o !== 9'h100 || vshamt_o !== 8'd0) begin n_fail++; $display("FAIL abort_csr: got %0d %0h %0h exp 0 100 0", vl_o, vtype_o, vshamt_o); end else n_pass++;
        vec_idle_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o === 1'b1 || vl_o !== 13'd0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_response: got %0d bad cycles exp 0", seen); end else n_pass++;
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_instr_i = '0; req_rs1_i = '0; req_rs2_i = '0;
        vec_idle_i = 1'b1; resp_ready_i = 1'b0;
        m_vl = '0; m_vtype = 9'h100; m_vshamt = '0;
        test_reset();
        test_vsetvli_basic();
        test_vlmax_modes();
        test_vill();
        test_stall();
        test_vsetsh_illegal();
        test_random();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
